// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake and feeds ID.
// Optional IF_PERF_CNT_EN adds saturating fetch and stall counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  // state  | meaning
  // S_REQ  | request outstanding to instruction memory, waiting for ack
  // S_HOLD | fetched word parked in hold buffer while ID is frozen
  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [31:0] PC_STEP = 32'(PC_INC);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic        kill;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        ack_in_req;

  assign pc_inc     = pc + PC_STEP;
  assign ack_in_req = (state == S_REQ) && imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (!branch_taken && imem_ack && !kill && freeze) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (branch_taken || !freeze) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Gated with rst so an abandoned request drops the instant reset is asserted.
  always_comb begin
    imem_req  = (state == S_REQ) && !rst;
    imem_addr = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= RESET_PC;
      kill            <= 1'b0;
      hold_pc         <= 32'h0;
      hold_instr      <= 32'h0;
      pc_out          <= 32'h0;
      instruction_out <= 32'h0;
      valid_out       <= 1'b0;
    end else if (branch_taken) begin
      // An unacked request is still in flight at memory; its data must be dropped.
      pc        <= branch_addr;
      valid_out <= 1'b0;
      kill      <= (state == S_REQ) && !imem_ack;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (kill) begin
              kill <= 1'b0;
              if (!freeze) valid_out <= 1'b0;
            end else if (freeze) begin
              hold_pc    <= pc_inc;
              hold_instr <= imem_rdata;
              pc         <= pc_inc;
            end else begin
              pc_out          <= pc_inc;
              instruction_out <= imem_rdata;
              valid_out       <= 1'b1;
              pc              <= pc_inc;
            end
          end else if (!freeze) begin
            valid_out <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            pc_out          <= hold_pc;
            instruction_out <= hold_instr;
            valid_out       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_hit;
  assign fetch_hit = ack_in_req && !kill && !branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 16'h0;
      perf_stall_cnt <= 16'h0;
    end else begin
      if (fetch_hit && (perf_fetch_cnt != 16'hFFFF)) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (freeze && (perf_stall_cnt != 16'hFFFF))    perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ack_in_req;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory model plus an expected-output queue.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  if_fetch_unit dut (
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];
  logic [31:0] exp_addr;
  logic        stale;
  logic        tb_hold;
  int          mem_wait;
  int          lat;
  int          n_fetch;
  int          n_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tb_clear();
    sb_q.delete();
    exp_addr = 32'h0;
    stale    = 1'b0;
    tb_hold  = 1'b0;
    mem_wait = 0;
    n_fetch  = 0;
    n_stall  = 0;
  endtask

  // One clock cycle: drive inputs, answer memory, predict, then check after the edge.
  task automatic step(input logic f, input logic b, input logic [31:0] ba);
    logic        ack;
    logic        req_b;
    logic        deliver;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_valid;
    logic [63:0] e;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    req_b        = imem_req;
    ack          = imem_req && (mem_wait >= lat);
    imem_ack     = ack;
    imem_rdata   = ack ? (imem_addr ^ KEY) : $urandom();
    if (imem_req) chk("imem_addr", imem_addr, exp_addr);
    chk("imem_req", imem_req, !tb_hold);
    deliver = 1'b0;
    if (b) begin
      sb_q.delete();
      tb_hold  = 1'b0;
      stale    = imem_req && !ack;
      exp_addr = ba;
    end else if (tb_hold) begin
      if (!f) begin
        deliver = 1'b1;
        tb_hold = 1'b0;
      end
    end else if (ack) begin
      if (stale) stale = 1'b0;
      else begin
        sb_q.push_back({exp_addr + 32'd4, exp_addr ^ KEY});
        exp_addr = exp_addr + 32'd4;
        n_fetch++;
        if (f) tb_hold = 1'b1;
        else   deliver = 1'b1;
      end
    end
    if (f) n_stall++;
    prev_pc    = pc_out;
    prev_instr = instruction_out;
    prev_valid = valid_out;
    @(posedge clk);
    #1;
    if (ack)        mem_wait = 0;
    else if (req_b) mem_wait++;
    if (b) begin
      chk("branch_valid", valid_out, 1'b0);
      chk("branch_pc_keep", pc_out, prev_pc);
    end else if (f) begin
      chk("frz_pc", pc_out, prev_pc);
      chk("frz_instr", instruction_out, prev_instr);
      chk("frz_valid", valid_out, prev_valid);
    end else begin
      chk("valid", valid_out, deliver);
      if (deliver) begin
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("pc_out", pc_out, e[63:32]);
          chk("instr", instruction_out, e[31:0]);
        end
      end
    end
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tb_clear();
    lat = 0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_valid", valid_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h0);

    // zero-wait stream: fetch 0 and 4, then freeze while 8 acks
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_frz_pc", pc_out, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("hold_req", imem_req, 1'b0);
      chk("hold_pc", pc_out, 32'h8);
    end
    step(0, 0, 0);
    chk("rel_pc", pc_out, 32'd12);
    chk("rel_instr", instruction_out, 32'h8 ^ KEY);
    chk("rel_next_addr", imem_addr, 32'd12);
    step(0, 0, 0);

    // branch while fetch of 16 is outstanding, ack one cycle later
    lat = 1;
    chk("pre_br_addr", imem_addr, 32'd16);
    step(0, 1, 32'h100);
    chk("br_addr", imem_addr, 32'h100);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("br_pc_out", pc_out, 32'h104);

    // two-cycle memory with a freeze while waiting
    lat = 2;
    for (int i = 0; i < 7; i++) step((i == 4), 0, 0);

    // branch out of HOLD while still frozen
    lat = 0;
    while (imem_req !== 1'b1) step(0, 0, 0);
    step(1, 0, 0);
    chk("hold2_req", imem_req, 1'b0);
    step(1, 1, 32'h200);
    chk("hb_addr", imem_addr, 32'h200);
    chk("hb_req", imem_req, 1'b1);
    step(0, 0, 0);
    step(0, 0, 0);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", pc_out, 32'h0);
    step(0, 0, 0);

    // back-to-back branches while a slow fetch is in flight, then reset mid-request
    lat = 2;
    step(0, 1, 32'h80);
    step(0, 1, 32'h40);
    step(0, 0, 0);
    chk("mid_addr", imem_addr, 32'h40);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, n_fetch[15:0]);
    chk("perf_stall", perf_stall_cnt, n_stall[15:0]);
`endif
    rst = 1'b1; freeze = 1'b0;
    #1;
    chk("mrst_req", imem_req, 1'b0);
    chk("mrst_pc_out", pc_out, 32'h0);
    chk("mrst_instr", instruction_out, 32'h0);
    chk("mrst_valid", valid_out, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tb_clear();
    lat = 0;
    #1;
    chk("mrel_req", imem_req, 1'b1);
    chk("mrel_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("mrel_perf_fetch", perf_fetch_cnt, 16'h0);
    chk("mrel_perf_stall", perf_stall_cnt, 16'h0);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("final_pc", pc_out, 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
